// File: rtl/cpld_romcfg_if.sv
// cpld_romcfg bus bundle: decode address bits, data bus and the mapper outputs.
// The master side drives the CPU bus and the slave side is the mapper.
interface cpld_romcfg_if;
  logic       adr13;
  logic       adr10;
  logic       adr14;
  logic [7:0] data;
  logic [5:0] rom16k_cs;
  logic       romdis;
  logic       unlocked;
  logic [7:0] romsel_q;

  modport slave (
    input  adr13,
    input  adr10,
    input  adr14,
    input  data,
    output rom16k_cs,
    output romdis,
    output unlocked,
    output romsel_q
  );

  modport master (
    output adr13,
    output adr10,
    output adr14,
    output data,
    input  rom16k_cs,
    input  romdis,
    input  unlocked,
    input  romsel_q
  );
endinterface

// File: rtl/cpld_romcfg.sv
// cpld_romcfg: key-protected ROM socket mapper clocked by the IO-write strobe.
// Optional relock timeout is built when ROMCFG_TIMEOUT_EN is defined.
module cpld_romcfg #(
  parameter logic [7:0] KEY0 = 8'h52,
  parameter logic [7:0] KEY1 = 8'h53,
  parameter logic [7:0] KEY2 = 8'h43
`ifdef ROMCFG_TIMEOUT_EN
  ,
  parameter int TMO_W = 6
`endif
) (
  input  logic         wclk,
  input  logic         reset_b,
  cpld_romcfg_if.slave bus
);

  typedef enum logic [2:0] {
    S_LOCK,
    S_K1,
    S_K2,
    S_IDX,
    S_DATA
  } state_t;

  state_t     st_q;
  state_t     st_d;
  state_t     st_base;
  logic [2:0] idx_q;
  logic       idx_ld;
  logic       map_we;
  logic [7:0] map_q [6];
  logic [7:0] romsel_q;
  logic       is_sel;
  logic       is_cfg;
  logic       unl;
  logic       force_lock;
  logic [5:0] cand;
  logic [5:0] cs;

  assign is_sel = ~bus.adr13;
  assign is_cfg = bus.adr13 & ~bus.adr10;
  assign unl    = (st_q == S_IDX) || (st_q == S_DATA);

`ifdef ROMCFG_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_q;

  assign force_lock = unl & (&tmo_q);

  // Relock timer: counts non-config writes while unlocked.
  always_ff @(posedge wclk or negedge reset_b) begin
    if (!reset_b) begin
      tmo_q <= '0;
    end else if (is_cfg || force_lock || !unl) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_q + 1'b1;
    end
  end
`else
  assign force_lock = 1'b0;
`endif

  // Unlock protocol and index/data sequencing.
  always_comb begin
    st_base = force_lock ? S_LOCK : st_q;
    st_d    = st_base;
    idx_ld  = 1'b0;
    map_we  = 1'b0;
    if (is_cfg) begin
      unique case (st_base)
        S_LOCK: begin
          if (bus.data == KEY0) st_d = S_K1;
        end
        S_K1: begin
          unique case (1'b1)
            (bus.data == KEY1): st_d = S_K2;
            (bus.data == KEY0): st_d = S_K1;
            default:            st_d = S_LOCK;
          endcase
        end
        S_K2: begin
          unique case (1'b1)
            (bus.data == KEY2): st_d = S_IDX;
            (bus.data == KEY0): st_d = S_K1;
            default:            st_d = S_LOCK;
          endcase
        end
        S_IDX: begin
          if (bus.data[7]) begin
            st_d = S_LOCK;
          end else begin
            idx_ld = 1'b1;
            if (bus.data[2:0] <= 3'd5) st_d = S_DATA;
          end
        end
        S_DATA: begin
          map_we = 1'b1;
          st_d   = S_IDX;
        end
        default: st_d = S_LOCK;
      endcase
    end
  end

  // State, index and ROM-select capture.
  always_ff @(posedge wclk or negedge reset_b) begin
    if (!reset_b) begin
      st_q     <= S_LOCK;
      idx_q    <= 3'd0;
      romsel_q <= 8'h00;
    end else begin
      st_q <= st_d;
      if (idx_ld) idx_q <= bus.data[2:0];
      if (is_sel) romsel_q <= bus.data;
    end
  end

  // Socket map: entry 0 replaces lower ROM, 1..5 serve ROMs 0..4.
  always_ff @(posedge wclk or negedge reset_b) begin
    if (!reset_b) begin
      map_q[0] <= 8'hC0;
      map_q[1] <= 8'h80;
      map_q[2] <= 8'h81;
      map_q[3] <= 8'h82;
      map_q[4] <= 8'h83;
      map_q[5] <= 8'h84;
    end else if (map_we) begin
      map_q[idx_q] <= {bus.data[7:6], 2'b00, bus.data[3:0]};
    end
  end

  // Candidate sockets for the current window.
  always_comb begin
    cand = '0;
    for (int i = 0; i < 6; i++) begin
      if (bus.adr14) begin
        cand[i] = map_q[i][7] & ~map_q[i][6] &
                  (romsel_q == {4'h0, map_q[i][3:0]});
      end else begin
        cand[i] = map_q[i][7] & map_q[i][6];
      end
    end
  end

  // Lowest-numbered candidate wins.
  always_comb begin
    cs = '0;
    for (int i = 5; i >= 0; i--) begin
      if (cand[i]) cs = 6'(1 << i);
    end
  end

  assign bus.rom16k_cs = cs;
  assign bus.romdis    = |cs;
  assign bus.unlocked  = unl;
  assign bus.romsel_q  = romsel_q;

endmodule

// File: doc/cpld_romcfg.md
# cpld_romcfg

Software-configurable upper/lower ROM mapper for the six-socket ROM board. It is clocked by the gated IO-write strobe and captures the CPC ROM-select byte from port &DFxx. It also runs a key-protected configuration protocol on port &FBxx that programs six socket map entries. A combinational arbiter turns the map, the current ROM-select byte and the memory address into one-hot 16K chip selects and ROMDIS, replacing fixed DIP decoding.

## Interface
Parameters:
- KEY0, 8'h52: first unlock byte
- KEY1, 8'h53: second unlock byte
- KEY2, 8'h43: third unlock byte
- TMO_W, 6: relock-timeout counter width (only with ROMCFG_TIMEOUT_EN)

Ports:
- wclk  in  1  rising edge at the end of every CPU IO write; it carries no other edges
- reset_b  in  1  asynchronous, active-low reset
- adr13  in  1  address bit 13; sampled at wclk↑ for port decode and not used elsewhere
- adr10  in  1  address bit 10; sampled at wclk↑ for port decode
- adr14  in  1  live memory address bit 14; 0 selects the lower-ROM window, 1 the upper
- data  in  8  CPU data bus, sampled at wclk↑
- rom16k_cs  out  6  one-hot or zero socket-half select, combinational
- romdis  out  1  OR of rom16k_cs
- unlocked  out  1  high while the FSM is in IDX or DATA
- romsel_q  out  8  last ROM-select byte written

## Operation
- Port decode at wclk↑:
  - ROMSEL write when adr13=0.
  - CFG write when adr13=1 and adr10=0.
  - All other writes are ignored, apart from the timeout count.
- ROMSEL write: romsel_q ← data. The FSM is unaffected.
- Map registers map[0..5], 8 bits each:
  - [7] enable
  - [6] lower (the entry serves the adr14=0 window)
  - [5:4] reserved; write-ignored, read as 0
  - [3:0] ROM number
- FSM states and transitions (CFG writes only):
  - LOCK: data=KEY0 → K1; otherwise stay.
  - K1: data=KEY1 → K2; data=KEY0 → K1; otherwise → LOCK.
  - K2: data=KEY2 → IDX; data=KEY0 → K1; otherwise → LOCK.
  - IDX: data[7]=1 → LOCK. Otherwise idx ← data[2:0]; idx ≤ 5 → DATA; idx 6 or 7 → stay IDX with no write.
  - DATA: map[idx] ← {data[7:6],2'b00,data[3:0]} → IDX.
- Socket arbitration (combinational):
  - adr14=0: candidate i = en[i] & lower[i].
  - adr14=1: candidate i = en[i] & ~lower[i] & (romsel_q == {4'h0,rom[i]}).
  - rom16k_cs asserts only the lowest-numbered candidate; all others are 0. There is never more than one bit set.

## Timing
- Reset (async, reset_b low):
  - FSM ← LOCK, romsel_q ← 8'h00.
  - map[0]=8'hC0 (lower-ROM replacement).
  - map[1]=8'h80, map[2]=8'h81, map[3]=8'h82, map[4]=8'h83, map[5]=8'h84.
  - unlocked=0, timeout counter=0.
- All register updates occur at wclk↑ and are visible on outputs immediately afterwards. rom16k_cs and romdis follow adr14 and romsel_q combinationally, with zero-cycle latency.
- Writes take effect on the write that completes them: the KEY2 write sets unlocked; the DATA write updates the map and the selects.
- Reset asserted mid-sequence (K1, K2, DATA) discards the partial state. A half-entered index is not written.

## Configuration
- ROMCFG_TIMEOUT_EN defined:
  - A TMO_W-bit counter clears on every CFG write and on entry to IDX.
  - The counter increments on any other IO write while unlocked.
  - When it reaches all-ones, the next wclk↑ forces the FSM to LOCK. A CFG write on that same edge is processed as in LOCK.
- ROMCFG_TIMEOUT_EN undefined: no counter exists, and the FSM stays unlocked until an IDX write with data[7]=1 or a reset.

## Test plan
- Reset, then ROMSEL 8'h03 with adr14=1 → rom16k_cs=6'b010000, romdis=1. With adr14=0 → rom16k_cs=6'b000001.
- Locked: CFG writes 8'h00, 8'h85 → map unchanged, unlocked=0. Then KEY0, KEY1, 8'h99, KEY0, KEY1, KEY2 → unlocked=1 only after the last write.
- Unlocked: CFG writes 8'h02, 8'h8A, then ROMSEL 8'h0A with adr14=1 → rom16k_cs=6'b000100. Then ROMSEL 8'h1A → rom16k_cs=0, romdis=0.
- Duplicate mapping: program map[4]=8'h81 → ROMSEL 8'h01 asserts only bit 2. Clear map[2] enable → bit 4 asserts.
- Indices and lock: index writes 8'h06 and 8'h07 → stays IDX, no map change. Then CFG 8'h80 → unlocked=0, and a following 8'h05/8'h80 pair has no effect.
- With ROMCFG_TIMEOUT_EN: unlock, then 63 ROMSEL writes → still unlocked; the 64th → unlocked=0. Assert reset_b during DATA → map equals the reset values.
